// File: rtl/miriscv_fetch_pkg.sv
// Fetch-stage types: the buffered {pc, instr} entry, the bubble word and the PC alignment helper.
package miriscv_fetch_pkg;
   import miriscv_pkg::*;

   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & {{(XLEN-2){1'b1}}, 2'b00};
   endfunction
endpackage

// File: rtl/miriscv_pkg.sv
// Core-wide architectural widths shared by every miriscv pipeline stage.
package miriscv_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;
endpackage

// File: rtl/miriscv_fetch_chk.sv
// Checker for the fetch buffer: the issue credit must make a push into a full buffer impossible.
module miriscv_fetch_chk (
   input logic clk_i,
   input logic arstn_i,
   input logic push_i,
   input logic full_i,
   input logic flush_i
);
   a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!arstn_i)
      !(push_i && full_i && !flush_i));
endmodule

// File: rtl/miriscv_fetch_fifo.sv
// Instruction buffer: synchronous FIFO of fetch entries; flush empties it and beats a same-cycle push.
module miriscv_fetch_fifo
   import miriscv_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
)(
   input  logic                   clk_i,
   input  logic                   arstn_i,
   input  logic                   push_i,
   input  fetch_entry_t           data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o,
   output fetch_entry_t           head_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push_s;
   logic          do_pop_s;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == {CW{1'b0}});
   assign count_o   = count_q;
   assign head_o    = mem_q[rd_ptr_q];
   assign do_push_s = push_i & ~flush_i & ~full_o;
   assign do_pop_s  = pop_i & ~flush_i & ~empty_o;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else if (flush_i) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied.
   always_ff @(posedge clk_i) begin
      if (do_push_s) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/miriscv_fetch_stage.sv
// miriscv fetch stage: credit-limited sequential fetch, in-order response buffering and
// kill/redirect handling with discard of responses still in flight.
module miriscv_fetch_stage
   import miriscv_pkg::*;
   import miriscv_fetch_pkg::*;
#(
   parameter int unsigned     FIFO_DEPTH = 2,
   parameter logic [ILEN-1:0] NOP_INSTR  = miriscv_fetch_pkg::NOP_INSTR
)(
   input  logic            clk_i,
   input  logic            arstn_i,
   input  logic [XLEN-1:0] boot_addr_i,
   output logic            instr_req_o,
   output logic [XLEN-1:0] instr_addr_o,
   input  logic            instr_rvalid_i,
   input  logic [ILEN-1:0] instr_rdata_i,
   output logic [ILEN-1:0] f_instr_o,
   output logic [XLEN-1:0] f_current_pc_o,
   output logic [XLEN-1:0] f_next_pc_o,
   output logic            f_valid_o,
   input  logic [XLEN-1:0] cu_pc_bra_i,
   input  logic            cu_boot_addr_load_en_i,
   input  logic            cu_stall_f_i,
   input  logic            cu_kill_f_i
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic            run_q;
   logic            boot_s, redirect_s, issue_s, rsp_s, push_s, pop_s, flush_s;
   logic            fifo_full_s, fifo_empty_s;
   logic [CW-1:0]   fifo_count_s;
   fetch_entry_t    head_s;
   fetch_entry_t    push_data_s;

   assign boot_s      = cu_boot_addr_load_en_i;
   assign redirect_s  = cu_kill_f_i & ~cu_stall_f_i & ~boot_s;
   // Buffer slots are reserved at issue time, so a response always has somewhere to land.
   assign issue_s     = run_q & ~boot_s & ~redirect_s &
                        ((outstanding_q + fifo_count_s) < CW'(FIFO_DEPTH));
   assign rsp_s       = instr_rvalid_i & (outstanding_q != {CW{1'b0}});
   assign push_s      = rsp_s & (discard_q == {CW{1'b0}}) & ~redirect_s & ~boot_s;
   assign pop_s       = f_valid_o & ~cu_stall_f_i;
   assign flush_s     = boot_s | redirect_s;
   assign push_data_s = {rsp_pc_q, instr_rdata_i};

   assign instr_req_o    = issue_s;
   assign instr_addr_o   = pc_q;
   assign f_valid_o      = ~fifo_empty_s;
   assign f_instr_o      = f_valid_o ? head_s.instr : NOP_INSTR;
   assign f_current_pc_o = f_valid_o ? head_s.pc : {XLEN{1'b0}};
   assign f_next_pc_o    = f_current_pc_o + XLEN'(4);

   // Next fetch/response PCs and in-flight accounting; boot outranks redirect.
   always_comb begin
      pc_d          = pc_q;
      rsp_pc_d      = rsp_pc_q;
      discard_d     = discard_q;
      outstanding_d = outstanding_q + CW'(issue_s) - CW'(rsp_s);
      if (boot_s) begin
         pc_d      = word_align(boot_addr_i);
         rsp_pc_d  = word_align(boot_addr_i);
         discard_d = outstanding_q - CW'(rsp_s);
      end else if (redirect_s) begin
         pc_d      = word_align(cu_pc_bra_i);
         rsp_pc_d  = word_align(cu_pc_bra_i);
         discard_d = outstanding_q - CW'(rsp_s);
      end else begin
         if (issue_s) pc_d = pc_q + XLEN'(4);
         else         pc_d = pc_q;
         if (push_s)  rsp_pc_d = rsp_pc_q + XLEN'(4);
         else         rsp_pc_d = rsp_pc_q;
         if (rsp_s && (discard_q != {CW{1'b0}})) discard_d = discard_q - CW'(1);
         else                                    discard_d = discard_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         pc_q          <= {XLEN{1'b0}};
         rsp_pc_q      <= {XLEN{1'b0}};
         outstanding_q <= {CW{1'b0}};
         discard_q     <= {CW{1'b0}};
         run_q         <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         run_q         <= 1'b1;
      end
   end

   miriscv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .push_i  (push_s),
      .data_i  (push_data_s),
      .pop_i   (pop_s),
      .flush_i (flush_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s),
      .head_o  (head_s)
   );

   miriscv_fetch_chk u_chk (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .push_i  (push_s),
      .full_i  (fifo_full_s),
      .flush_i (flush_s)
   );
endmodule

// File: tb/tb_miriscv_fetch_stage.sv
// Randomised bench for miriscv_fetch_stage: an in-order memory with variable latency and a
// stream-level model of the PCs decode must see and the addresses fetch must request.
module tb_miriscv_fetch_stage;
   localparam int          FIFO_DEPTH = 2;
   localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic [31:0] boot_addr_i;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic [31:0] f_instr_o;
   logic [31:0] f_current_pc_o;
   logic [31:0] f_next_pc_o;
   logic        f_valid_o;
   logic [31:0] cu_pc_bra_i;
   logic        cu_boot_addr_load_en_i;
   logic        cu_stall_f_i;
   logic        cu_kill_f_i;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        mq[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          n_del    = 0;
   int          lat_fix  = 1;
   int          first_req_cyc, first_val_cyc;
   logic [31:0] exp_req  = 32'h0;
   logic [31:0] exp_del  = 32'h0;
   logic [31:0] next_bra = 32'h0;
   logic        boot_req = 1'b0;
   logic [31:0] boot_addr_v = 32'h0;
   logic        stale_inject = 1'b0;
   logic        last_req, last_valid;
   logic [31:0] last_pc, last_instr;

   miriscv_fetch_stage #(.FIFO_DEPTH(FIFO_DEPTH), .NOP_INSTR(NOP_WORD)) dut (
      .clk_i                  (clk_i),
      .arstn_i                (arstn_i),
      .boot_addr_i            (boot_addr_i),
      .instr_req_o            (instr_req_o),
      .instr_addr_o           (instr_addr_o),
      .instr_rvalid_i         (instr_rvalid_i),
      .instr_rdata_i          (instr_rdata_i),
      .f_instr_o              (f_instr_o),
      .f_current_pc_o         (f_current_pc_o),
      .f_next_pc_o            (f_next_pc_o),
      .f_valid_o              (f_valid_o),
      .cu_pc_bra_i            (cu_pc_bra_i),
      .cu_boot_addr_load_en_i (cu_boot_addr_load_en_i),
      .cu_stall_f_i           (cu_stall_f_i),
      .cu_kill_f_i            (cu_kill_f_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] align4(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] pick_target();
      case ($urandom_range(0, 3))
         0: return 32'hFFFF_FFF8;
         1: return $urandom_range(0, 32'h0000_0FFF);
         default: return $urandom;
      endcase
   endfunction

   // One clock: drive at posedge+1, check and update the model at negedge, return at next posedge.
   task automatic run_cycle(input int stall_mode, input int kill_mode);
      logic redir;
      req_t r;
      #1;
      cyc++;
      if (stale_inject) begin
         instr_rvalid_i = 1'b1;
         instr_rdata_i  = 32'hDEAD_BEEF;
         stale_inject   = 1'b0;
      end else if (mq.size() != 0 && mq[0].due <= cyc) begin
         instr_rvalid_i = 1'b1;
         instr_rdata_i  = mem_word(mq[0].addr);
         mq.delete(0);
      end else begin
         instr_rvalid_i = 1'b0;
         instr_rdata_i  = $urandom;
      end
      cu_stall_f_i = (stall_mode == 1) || (stall_mode == 2 && $urandom_range(0, 3) == 0);
      cu_kill_f_i  = (kill_mode == 1) || (kill_mode == 2 && f_valid_o && $urandom_range(0, 7) == 0);
      if (kill_mode == 2 && cu_kill_f_i) next_bra = pick_target();
      cu_pc_bra_i            = next_bra;
      cu_boot_addr_load_en_i = boot_req;
      boot_addr_i            = boot_addr_v;
      @(negedge clk_i);
      redir      = cu_kill_f_i && !cu_stall_f_i && !cu_boot_addr_load_en_i;
      last_req   = instr_req_o;
      last_valid = f_valid_o;
      last_pc    = f_current_pc_o;
      last_instr = f_instr_o;
      if (cu_boot_addr_load_en_i || redir) check_eq("req_blocked", 32'(instr_req_o), 32'd0);
      if (instr_req_o) begin
         check_eq("req_addr", instr_addr_o, exp_req);
         if (first_req_cyc < 0) first_req_cyc = cyc;
         r.addr = instr_addr_o;
         r.due  = cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3)));
         mq.push_back(r);
         check_eq("credit", 32'(mq.size() <= FIFO_DEPTH), 32'd1);
         exp_req = exp_req + 32'd4;
      end
      if (f_valid_o) begin
         if (first_val_cyc < 0) first_val_cyc = cyc;
         check_eq("head_pc", f_current_pc_o, exp_del);
         check_eq("head_instr", f_instr_o, mem_word(exp_del));
         check_eq("next_pc", f_next_pc_o, exp_del + 32'd4);
         if (!cu_stall_f_i) begin
            n_del++;
            exp_del = exp_del + 32'd4;
         end
      end else begin
         check_eq("bubble_nop", f_instr_o, NOP_WORD);
      end
      if (redir) begin
         exp_req = align4(cu_pc_bra_i);
         exp_del = align4(cu_pc_bra_i);
      end
      if (cu_boot_addr_load_en_i) begin
         exp_req = align4(boot_addr_i);
         exp_del = align4(boot_addr_i);
      end
      @(posedge clk_i);
   endtask

   task automatic run_until_valid(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         run_cycle(0, 0);
         seen = last_valid;
      end
      check_eq(tag, 32'(seen), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req"}, 32'(instr_req_o), 32'd0);
      check_eq({tag, "_addr"}, instr_addr_o, 32'd0);
      check_eq({tag, "_valid"}, 32'(f_valid_o), 32'd0);
      check_eq({tag, "_instr"}, f_instr_o, NOP_WORD);
      check_eq({tag, "_pc"}, f_current_pc_o, 32'd0);
      check_eq({tag, "_npc"}, f_next_pc_o, 32'd4);
   endtask

   initial begin
      logic [31:0] pc_hold, instr_hold;
      int          n0;
      bit          found;
      arstn_i = 1'b0; boot_addr_i = 32'h0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
      cu_pc_bra_i = 32'h0; cu_boot_addr_load_en_i = 1'b0; cu_stall_f_i = 1'b0; cu_kill_f_i = 1'b0;
      #12;
      check_reset_outputs("reset");
      @(negedge clk_i);
      arstn_i = 1'b1;
      @(posedge clk_i);

      // boot at 0x8000_0000 then a plain stream at latency 1
      boot_addr_v = 32'h8000_0000; boot_req = 1'b1; lat_fix = 1;
      first_req_cyc = -1; first_val_cyc = -1;
      run_cycle(0, 0);
      run_cycle(0, 0);
      boot_req = 1'b0;
      repeat (20) run_cycle(0, 0);
      check_eq("first_valid_delay", 32'(first_val_cyc - first_req_cyc), 32'd2);
      check_eq("stream_progress", 32'(n_del >= 10), 32'd1);

      // three-cycle stall: head held, no request once the buffer fills
      run_cycle(1, 0);
      run_cycle(1, 0);
      pc_hold = last_pc; instr_hold = last_instr;
      run_cycle(1, 0);
      check_eq("stall_valid", 32'(last_valid), 32'd1);
      check_eq("stall_req", 32'(last_req), 32'd0);
      check_eq("stall_pc_hold", last_pc, pc_hold);
      check_eq("stall_instr_hold", last_instr, instr_hold);
      repeat (10) run_cycle(0, 0);

      // redirect to 0x100 with two requests in flight at latency 3
      lat_fix = 3; found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (mq.size() == 2 && mq[0].due > cyc + 1) begin
            next_bra = 32'h0000_0100;
            run_cycle(0, 1);
            found = 1'b1;
         end else begin
            run_cycle(0, 0);
         end
      end
      check_eq("redir_setup", 32'(found), 32'd1);
      run_until_valid("redir_seen");
      check_eq("redir_pc", last_pc, 32'h0000_0100);
      check_eq("redir_instr", last_instr, mem_word(32'h0000_0100));

      // kill under stall is ignored; the later unstalled kill redirects
      lat_fix = 1;
      run_cycle(1, 0);
      run_cycle(1, 0);
      pc_hold = last_pc;
      next_bra = 32'h0000_0800;
      run_cycle(1, 1);
      run_cycle(1, 0);
      check_eq("stall_kill_valid", 32'(last_valid), 32'd1);
      check_eq("stall_kill_pc", last_pc, pc_hold);
      next_bra = 32'h0000_0400;
      run_cycle(0, 1);
      run_until_valid("kill_seen");
      check_eq("kill_pc", last_pc, 32'h0000_0400);

      // address wrap and low-bit masking of the target
      next_bra = 32'hFFFF_FFFC;
      run_cycle(0, 1);
      run_until_valid("wrap_seen0");
      check_eq("wrap_pc0", last_pc, 32'hFFFF_FFFC);
      run_until_valid("wrap_seen1");
      check_eq("wrap_pc1", last_pc, 32'h0000_0000);
      next_bra = 32'h0000_0203;
      run_cycle(0, 1);
      run_until_valid("align_seen");
      check_eq("align_pc", last_pc, 32'h0000_0200);

      // random stalls, kills and latencies
      lat_fix = 0; n0 = n_del;
      repeat (2000) run_cycle(2, 2);
      check_eq("random_progress", 32'(n_del - n0 > 300), 32'd1);

      // asynchronous reset mid-stream, then a stale response right after release
      #2;
      arstn_i = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      mq.delete();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      arstn_i = 1'b1;
      @(posedge clk_i);
      exp_req = 32'h0; exp_del = 32'h0; lat_fix = 1; stale_inject = 1'b1;
      run_cycle(0, 0);
      check_eq("post_reset_req", 32'(last_req), 32'd1);
      run_until_valid("post_reset_seen");
      check_eq("post_reset_pc", last_pc, 32'h0000_0000);
      check_eq("post_reset_instr", last_instr, mem_word(32'h0000_0000));
      repeat (10) run_cycle(0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
